// File: rtl/data_memory_ctrl_if.sv
// Request/response bus for data_memory_ctrl: one request channel (valid/ready)
// and a registered, in-order response pulse.
interface data_memory_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic              req_unsigned;
  logic [1:0]        req_width;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  modport master (
    output req_valid, req_wr, req_unsigned, req_width, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_wr, req_unsigned, req_width, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-lane data memory controller: per-lane synchronous RAMs, steered stores,
// little-endian load assembly. `define MISALIGN_SPLIT_EN to split lane-crossing accesses.
module data_memory_lane #(
  parameter int WA_W = 13
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [WA_W-1:0] addr,
  input  logic [7:0]      wdata,
  output logic [7:0]      rdata
);
  logic [7:0] mem [2**WA_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

module data_memory_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
) (
  input  logic clk,
  input  logic rst_n,
  data_memory_ctrl_if.slave bus
);
  localparam int LANES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int WA_W   = ADDR_W - OFF_W;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, BEAT2, RESP} state_t;
  typedef struct packed {
    logic             wr;
    logic             uns;
    logic             err;
    logic [1:0]       width;
    logic [OFF_W-1:0] off;
  } meta_t;

  state_t state, state_nxt;
  logic   ready_q, accept, in_b2, issue;
  logic   width_bad, illegal, need_split;
  logic [3:0]       size;
  logic [OFF_W-1:0] off;
  logic [WA_W-1:0]  word, b_word;
  logic [LANES-1:0] act, lo, b_act2, lane_en, lane_we;
  logic [LANES-1:0][OFF_W-1:0] rel;
  logic [LANES-1:0][7:0]       wbytes, wrot, b_wrot, lane_wd, lane_rd, data2, rot;
  logic [LANES-1:0][WA_W-1:0]  lane_addr;
  logic [STAGES:0] vld_pipe;
  meta_t req_meta, b_meta, meta0, meta1, meta2;

  assign in_b2         = (state == BEAT2);
  assign bus.req_ready = ready_q && !in_b2;
  assign accept        = bus.req_valid && bus.req_ready;
  assign off           = bus.req_addr[OFF_W-1:0];
  assign word          = bus.req_addr[ADDR_W-1:OFF_W];
  assign wbytes        = bus.req_wdata;

  always_comb begin
    case (bus.req_width)
      2'b01:   size = 4'd1;
      2'b10:   size = 4'd2;
      2'b00:   size = 4'd4;
      default: size = 4'd8;
    endcase
  end

  assign width_bad = size > 4'(LANES);

`ifdef MISALIGN_SPLIT_EN
  logic crossing;
  assign crossing   = (5'(off) + 5'(size)) > 5'(LANES);
  assign illegal    = width_bad;
  assign need_split = crossing && !width_bad;
`else
  logic [OFF_W-1:0] amask;
  logic             misaligned;
  assign amask      = OFF_W'(size - 4'd1);
  assign misaligned = |(off & amask);
  assign illegal    = width_bad || misaligned;
  assign need_split = 1'b0;
`endif

  assign req_meta = '{wr: bus.req_wr, uns: bus.req_unsigned, err: illegal,
                      width: bus.req_width, off: off};

  // Lane i carries request byte rel = i - off (mod LANES); lanes below off belong to beat 2.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign rel[i]       = OFF_W'(i) - off;
    assign act[i]       = 4'(rel[i]) < size;
    assign lo[i]        = OFF_W'(i) < off;
    assign wrot[i]      = wbytes[rel[i]];
    assign lane_en[i]   = in_b2 ? b_act2[i] : (accept && !illegal && act[i] && !lo[i]);
    assign lane_we[i]   = in_b2 ? b_meta.wr : bus.req_wr;
    assign lane_addr[i] = in_b2 ? b_word + WA_W'(1) : word;
    assign lane_wd[i]   = in_b2 ? b_wrot[i] : wrot[i];
    assign rot[i]       = data2[OFF_W'(i) + meta2.off];

    data_memory_lane #(.WA_W(WA_W)) u_lane (
      .clk   (clk),
      .en    (lane_en[i]),
      .we    (lane_we[i]),
      .addr  (lane_addr[i]),
      .wdata (lane_wd[i]),
      .rdata (lane_rd[i])
    );
  end

  always_ff @(posedge clk) begin
    if (accept && need_split) begin
      b_meta <= req_meta;
      b_word <= word;
      b_act2 <= act & lo;
      b_wrot <= wrot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BEAT2:   state_nxt = RESP;
      default: begin
        if (accept)              state_nxt = need_split ? BEAT2 : RESP;
        else if (|vld_pipe[1:0]) state_nxt = RESP;
        else                     state_nxt = IDLE;
      end
    endcase
  end

  // The final beat of a request issues the pipeline token; a split request issues in BEAT2.
  assign issue = in_b2 || (accept && !need_split);
  assign meta0 = in_b2 ? b_meta : req_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], issue};
  end

  always_ff @(posedge clk) begin
    meta1 <= meta0;
    meta2 <= meta1;
    data2 <= lane_rd;
  end

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [1:0] w, input logic uns);
    logic [DATA_W-1:0] keep;
    logic              s;
    case (w)
      2'b01:   begin keep = DATA_W'(8'hFF);         s = d[7];  end
      2'b10:   begin keep = DATA_W'(16'hFFFF);      s = d[15]; end
      2'b00:   begin keep = DATA_W'(32'hFFFF_FFFF); s = d[31]; end
      default: begin keep = '1;                     s = 1'b0;  end
    endcase
    if (uns) s = 1'b0;
    return (d & keep) | ({DATA_W{s}} & ~keep);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
    end else if (vld_pipe[1]) begin
      bus.rsp_error <= meta2.err;
      bus.rsp_rdata <= (meta2.err || meta2.wr) ? '0 : extend(rot, meta2.width, meta2.uns);
    end
  end

  assign bus.rsp_valid = vld_pipe[2];
endmodule
